// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants used by the NTT butterfly and its helpers.
package kyber_pkg;

    localparam int unsigned Q          = 3329;
    localparam int unsigned W          = 12;
    localparam int unsigned IDXW       = 8;
    localparam int unsigned MUL_LAT    = 4;
    localparam int unsigned NTT_BF_LAT = MUL_LAT + 1;

endpackage

// File: rtl/ntt_butterfly_if.sv
// Butterfly sample bus: input pair/twiddle/tag and the returned result pair/tag.
interface ntt_butterfly_if;
    import kyber_pkg::*;

    logic            in_valid;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [W-1:0]    in_zeta;
    logic [IDXW-1:0] in_idx;
    logic            inv;
    logic            out_valid;
    logic [W-1:0]    out_a;
    logic [W-1:0]    out_b;
    logic [IDXW-1:0] out_idx;

    // Producer side: RAM read port / twiddle ROM, also consumes write-back results.
    modport master (
        output in_valid, in_a, in_b, in_zeta, in_idx, inv,
        input  out_valid, out_a, out_b, out_idx
    );

    // Butterfly side.
    modport slave (
        input  in_valid, in_a, in_b, in_zeta, in_idx, inv,
        output out_valid, out_a, out_b, out_idx
    );

endinterface

// File: rtl/mod_addsub.sv
// Combinational modular add/subtract: (x, y) -> ((x+y) mod Q, (x-y) mod Q), inputs in 0..Q-1.
module mod_addsub
    import kyber_pkg::*;
(
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] sum_c_o,
    output logic [W-1:0] dif_c_o
);

    logic [W:0] s_c;
    logic [W:0] d_c;

    // One conditional correction each; the top bit of d_c is the borrow.
    always_comb begin
        s_c     = {1'b0, x_i} + {1'b0, y_i};
        d_c     = {1'b0, x_i} - {1'b0, y_i};
        sum_c_o = (s_c >= (W+1)'(Q)) ? W'(s_c - (W+1)'(Q)) : W'(s_c);
        dif_c_o = d_c[W] ? W'(d_c + (W+1)'(Q)) : W'(d_c);
    end

endmodule

// File: rtl/mul_reduce.sv
// Pipelined modular multiply res = a*b mod Q using Barrett reduction; latency MUL_LAT (4).
module mul_reduce
    import kyber_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned RW = W + 2;
    localparam int unsigned BM = (1 << PW) / Q;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [PW-1:0] p_q;
    logic [RW-1:0] r_q;
    logic [W-1:0]  res_q;

    logic [W:0]    qe_c;
    logic [RW-1:0] r_c;
    logic [W-1:0]  fold_c;

    // Quotient estimate is at most one short, so the remainder is below 2Q and needs one fold.
    always_comb begin
        qe_c   = (W+1)'(((PW+W+1)'(p_q) * (PW+W+1)'(BM)) >> PW);
        r_c    = RW'(p_q - PW'(qe_c * Q));
        fold_c = (r_q >= RW'(Q)) ? W'(r_q - RW'(Q)) : W'(r_q);
    end

    // Input register, product, Barrett remainder, final fold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            r_q   <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            p_q   <= PW'(a_q) * PW'(b_q);
            r_q   <= r_c;
            res_q <= fold_c;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/ntt_butterfly.sv
// Fully pipelined Kyber NTT butterfly, one pair per cycle, latency NTT_BF_LAT (5).
// CT: a' = a + zeta*b, b' = a - zeta*b (mod Q).
// Define NTT_BF_GS_EN to add per-sample Gentleman-Sande mode selected by inv:
//   a' = a + b, b' = zeta*(a - b) (mod Q).
module ntt_butterfly
    import kyber_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    ntt_butterfly_if.slave bf
);

    logic [W-1:0]    mul_b_c;
    logic [W-1:0]    head_a_c;
    logic            head_inv_c;
    logic [W-1:0]    res;
    logic [W-1:0]    sum_c;
    logic [W-1:0]    dif_c;

    logic [W-1:0]    a_q   [MUL_LAT];
    logic [IDXW-1:0] idx_q [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q;
    logic [MUL_LAT-1:0] inv_q;

    logic            out_valid_q;
    logic [W-1:0]    out_a_q;
    logic [W-1:0]    out_b_q;
    logic [IDXW-1:0] out_idx_q;
    logic [W-1:0]    out_a_d;
    logic [W-1:0]    out_b_d;

`ifdef NTT_BF_GS_EN
    logic [W-1:0] s0_c;
    logic [W-1:0] d0_c;

    mod_addsub u_in_addsub (
        .x_i     (bf.in_a),
        .y_i     (bf.in_b),
        .sum_c_o (s0_c),
        .dif_c_o (d0_c)
    );

    // GS samples multiply the difference and carry the sum down the delay line.
    always_comb begin
        mul_b_c    = bf.in_b;
        head_a_c   = bf.in_a;
        head_inv_c = bf.inv;
        if (bf.inv) begin
            mul_b_c  = d0_c;
            head_a_c = s0_c;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = bf.inv;

    // CT only: b goes straight to the multiplier, a straight to the delay line.
    always_comb begin
        mul_b_c    = bf.in_b;
        head_a_c   = bf.in_a;
        head_inv_c = 1'b0;
    end
`endif

    mul_reduce u_mul (
        .clk   (clk),
        .rst   (~rst_n),
        .a_i   (bf.in_zeta),
        .b_i   (mul_b_c),
        .res_o (res)
    );

    // Delay line keeping a, tag, valid and mode aligned with the multiplier result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                a_q[i]   <= '0;
                idx_q[i] <= '0;
            end
            vld_q <= '0;
            inv_q <= '0;
        end else begin
            a_q[0]   <= head_a_c;
            idx_q[0] <= bf.in_idx;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                a_q[i]   <= a_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            vld_q <= {vld_q[MUL_LAT-2:0], bf.in_valid};
            inv_q <= {inv_q[MUL_LAT-2:0], head_inv_c};
        end
    end

    mod_addsub u_out_addsub (
        .x_i     (a_q[MUL_LAT-1]),
        .y_i     (res),
        .sum_c_o (sum_c),
        .dif_c_o (dif_c)
    );

    // Output selection: CT add/sub pair, or GS pass-through of sum and product.
    always_comb begin
        out_a_d = sum_c;
        out_b_d = dif_c;
        if (inv_q[MUL_LAT-1]) begin
            out_a_d = a_q[MUL_LAT-1];
            out_b_d = res;
        end
    end

    // Output register; data captured every cycle, valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= vld_q[MUL_LAT-1];
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_idx_q   <= idx_q[MUL_LAT-1];
        end
    end

    assign bf.out_valid = out_valid_q;
    assign bf.out_a     = out_a_q;
    assign bf.out_b     = out_b_q;
    assign bf.out_idx   = out_idx_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed cases plus a random stream with bubbles,
// compared cycle by cycle against a plain-arithmetic butterfly model.
module tb_ntt_butterfly;
    import kyber_pkg::*;

`ifdef NTT_BF_GS_EN
    localparam bit GS_EN = 1'b1;
`else
    localparam bit GS_EN = 1'b0;
`endif
    localparam int HN = 1024;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ntt_butterfly_if bf_if ();

    ntt_butterfly dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bf    (bf_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected output for the sample driven in each slot.
    bit hv [HN];
    int ha [HN];
    int hb [HN];
    int hi [HN];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference butterfly from the modular definitions.
    function automatic void model(input int a, input int b, input int z, input bit inv,
                                  output int ea, output int eb);
        int q;
        int t;
        q = int'(Q);
        if (GS_EN && inv) begin
            ea = (a + b) % q;
            eb = (z * ((a - b + q) % q)) % q;
        end else begin
            t  = (z * b) % q;
            ea = (a + t) % q;
            eb = (a - t + q) % q;
        end
    endfunction

    // Advance one clock and compare outputs against the sample driven five slots earlier.
    task automatic tick();
        bit ev;
        @(posedge clk);
        cyc++;
        #1;
        ev = (cyc >= NTT_BF_LAT) ? hv[cyc-NTT_BF_LAT] : 1'b0;
        check_val("out_valid", 32'(bf_if.out_valid), 32'(ev));
        if (ev) begin
            check_val("out_a",   32'(bf_if.out_a),   32'(ha[cyc-NTT_BF_LAT]));
            check_val("out_b",   32'(bf_if.out_b),   32'(hb[cyc-NTT_BF_LAT]));
            check_val("out_idx", 32'(bf_if.out_idx), 32'(hi[cyc-NTT_BF_LAT]));
        end
    endtask

    task automatic drive(input bit v, input int a, input int b, input int z, input int idx,
                         input bit inv);
        int ea;
        int eb;
        bf_if.in_valid = v;
        bf_if.in_a     = W'(a);
        bf_if.in_b     = W'(b);
        bf_if.in_zeta  = W'(z);
        bf_if.in_idx   = IDXW'(idx);
        bf_if.inv      = inv;
        model(a, b, z, inv, ea, eb);
        hv[cyc] = v;
        ha[cyc] = ea;
        hb[cyc] = eb;
        hi[cyc] = idx;
        tick();
    endtask

    task automatic rnd(output int x);
        x = int'($urandom_range(Q - 1, 0));
    endtask

    // Bubbles carrying random junk data.
    task automatic idle(input int n);
        int a, b, z;
        for (int i = 0; i < n; i++) begin
            rnd(a); rnd(b); rnd(z);
            drive(1'b0, a, b, z, int'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_valid"}, 32'(bf_if.out_valid), 32'd0);
        check_val({pfx, "_a"},     32'(bf_if.out_a),     32'd0);
        check_val({pfx, "_b"},     32'(bf_if.out_b),     32'd0);
        check_val({pfx, "_idx"},   32'(bf_if.out_idx),   32'd0);
    endtask

    initial begin
        int a, b, z;
        bit v, inv;

        rst_n          = 1'b0;
        bf_if.in_valid = 1'b0;
        bf_if.in_a     = '0;
        bf_if.in_b     = '0;
        bf_if.in_zeta  = '0;
        bf_if.in_idx   = '0;
        bf_if.inv      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic CT sample, then wrap/underflow pair back to back.
        drive(1'b1, 100, 2, 17, 5, 1'b0);
        idle(6);
        drive(1'b1, 3000, 1, 1000, 6, 1'b0);
        drive(1'b1, 5, 1, 10, 7, 1'b0);
        idle(6);

        // Random stream with valid pattern 1101, including zeta=0 and a=t samples.
        for (int i = 0; i < 64; i++) begin
            v = (i % 4) != 2;
            rnd(a); rnd(b); rnd(z);
            if (i % 16 == 5) z = 0;
            if (i % 16 == 9) a = (z * b) % int'(Q);
            inv = GS_EN ? 1'($urandom_range(1, 0)) : 1'b0;
            drive(v, a, b, z, i, inv);
        end
        idle(6);

        // Extremes: all Q-1, and a = t = Q-1.
        drive(1'b1, 3328, 3328, 3328, 8, 1'b0);
        drive(1'b1, 3328, 3328, 1, 9, 1'b0);
        drive(1'b1, 0, 0, 0, 10, 1'b0);
        idle(6);

        // GS samples interleaved with CT samples (inv ignored when GS is not built in).
        drive(1'b1, 10, 20, 17, 11, 1'b1);
        drive(1'b1, 100, 2, 17, 12, 1'b0);
        drive(1'b1, 10, 20, 17, 13, 1'b1);
        drive(1'b1, 20, 10, 0, 14, 1'b1);
        drive(1'b1, 3328, 0, 3328, 15, 1'b0);
        idle(6);

        // Reset with three samples in flight.
        drive(1'b1, 1, 2, 3, 20, 1'b0);
        drive(1'b1, 4, 5, 6, 21, 1'b0);
        drive(1'b1, 7, 8, 9, 22, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < HN; i++) hv[i] = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        check_zero("rst_hold");
        rst_n = 1'b1;
        drive(1'b1, 1234, 2345, 3000, 23, 1'b0);
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
